// File: rtl/stream_pattern_gen_if.sv
// Valid/ready word stream carrying generated test data from the pattern source to its consumer.
interface stream_pattern_gen_if #(
  parameter int unsigned DATA_W = 32
) ();
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/stream_pattern_gen.sv
// Rate-programmable test word source (incr / LFSR / walking-ones / constant) with burst and
// overrun accounting. Optional signature output enabled by STREAM_PATTERN_CHECKSUM_EN.
module stream_pattern_gen #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DIV_W     = 8,
  parameter int unsigned BURST_W   = 16,
  parameter int unsigned OVR_W     = 16,
  parameter logic [31:0] LFSR_TAPS = 32'h80200003
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 enable,
  input  logic                 start,
  input  logic                 stop,
  input  logic [1:0]           mode,
  input  logic [DATA_W-1:0]    seed,
  input  logic [DIV_W-1:0]     period,
  input  logic [BURST_W-1:0]   burst_len,
  stream_pattern_gen_if.master strm,
  output logic                 busy,
  output logic                 done,
  output logic [BURST_W-1:0]   beat_cnt,
`ifdef STREAM_PATTERN_CHECKSUM_EN
  output logic [DATA_W-1:0]    checksum,
`endif
  output logic [OVR_W-1:0]     overrun_cnt
);

  localparam logic [DATA_W-1:0] Taps = DATA_W'(LFSR_TAPS);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [DIV_W-1:0]   period_q, period_d;
  logic [BURST_W-1:0] blen_q, blen_d;
  logic [DIV_W-1:0]   timer_q, timer_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [BURST_W-1:0] beat_q, beat_d;
  logic [OVR_W-1:0]   ovr_q, ovr_d;

  logic accept, fire, launch, take;

  function automatic logic [DATA_W-1:0] next_word(input logic [1:0] m,
                                                  input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] n;
    n = w;
    unique case (m)
      2'd0: n = w + DATA_W'(1);
      2'd1: n = {w[DATA_W-2:0], ^(w & Taps)};
      2'd2: n = {w[DATA_W-2:0], w[DATA_W-1]};
      2'd3: n = w;
      default: n = w;
    endcase
    return n;
  endfunction

  function automatic logic [DATA_W-1:0] first_word(input logic [1:0] m,
                                                   input logic [DATA_W-1:0] s);
    logic [DATA_W-1:0] f;
    f = s;
    if (m == 2'd2 || (m == 2'd1 && s == '0)) begin
      f = DATA_W'(1);
    end
    return f;
  endfunction

  assign accept = valid_q && strm.ready;
  assign fire   = (state_q == StRun) && enable && (timer_q == period_q);
  assign launch = (state_q == StIdle) && start && !stop;
  assign take   = (state_q == StRun) && !stop && accept;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    period_d = period_q;
    blen_d   = blen_q;
    timer_d  = timer_q;
    data_d   = data_q;
    valid_d  = valid_q;
    beat_d   = beat_q;
    ovr_d    = ovr_q;

    unique case (state_q)
      StIdle: begin
        if (launch) begin
          state_d  = StRun;
          mode_d   = mode;
          period_d = period;
          blen_d   = burst_len;
          timer_d  = '0;
          beat_d   = '0;
          ovr_d    = '0;
          valid_d  = 1'b0;
          data_d   = first_word(mode, seed);
        end
      end
      StRun: begin
        if (stop) begin
          state_d = StIdle;
          valid_d = 1'b0;
        end else begin
          if (enable) begin
            timer_d = fire ? '0 : timer_q + DIV_W'(1);
          end
          if (take) begin
            data_d = next_word(mode_q, data_q);
            beat_d = beat_q + BURST_W'(1);
            // The final beat of a burst ends the run even if a new slot fires alongside it.
            if (blen_q != '0 && beat_d == blen_q) begin
              state_d = StDone;
              valid_d = 1'b0;
            end else begin
              valid_d = fire;
            end
          end else if (fire) begin
            if (!valid_q) begin
              valid_d = 1'b1;
            end else if (ovr_q != '1) begin
              ovr_d = ovr_q + OVR_W'(1);
            end
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        valid_d = 1'b0;
      end
      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d == StRun);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= StIdle;
      mode_q   <= 2'd0;
      period_q <= '0;
      blen_q   <= '0;
      timer_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      beat_q   <= '0;
      ovr_q    <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      period_q <= period_d;
      blen_q   <= blen_d;
      timer_q  <= timer_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      beat_q   <= beat_d;
      ovr_q    <= ovr_d;
    end
  end

  assign strm.data   = data_q;
  assign strm.valid  = valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign beat_cnt    = beat_q;
  assign overrun_cnt = ovr_q;

`ifdef STREAM_PATTERN_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (launch) begin
      checksum_d = '0;
    end else if (take) begin
      checksum_d = checksum_q ^ data_q;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`else
  // No signature register in the default build.
`endif

endmodule

// File: tb/tb_stream_pattern_gen.sv
// Bench for stream_pattern_gen: word-index reference model compared every cycle, plus
// directed scenarios with literal expectations; random runs exercise handshake and controls.
module tb_stream_pattern_gen;

  localparam logic [31:0] TAPS = 32'h80200003;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        enable = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [31:0] seed = 32'h0;
  logic [7:0]  period = 8'd0;
  logic [15:0] burst_len = 16'd0;
  logic        busy, done;
  logic [15:0] beat_cnt, overrun_cnt;
`ifdef STREAM_PATTERN_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  stream_pattern_gen_if #(.DATA_W(32)) strm ();

  stream_pattern_gen dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .enable     (enable),
    .start      (start),
    .stop       (stop),
    .mode       (mode),
    .seed       (seed),
    .period     (period),
    .burst_len  (burst_len),
    .strm       (strm),
    .busy       (busy),
    .done       (done),
    .beat_cnt   (beat_cnt),
`ifdef STREAM_PATTERN_CHECKSUM_EN
    .checksum   (checksum),
`endif
    .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] acc_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // k-th word of a run, straight from the pattern definitions.
  function automatic logic [31:0] word_at(input int md, input logic [31:0] sd, input int k);
    logic [31:0] w;
    case (md)
      0: w = sd + 32'(k);
      1: begin
        w = (sd == 32'h0) ? 32'h1 : sd;
        for (int i = 0; i < k; i++) w = {w[30:0], ^(w & TAPS)};
      end
      2: w = 32'h1 << (k % 32);
      default: w = sd;
    endcase
    return w;
  endfunction

  // Reference model: 0 idle, 1 run, 2 done; words indexed by accepted-beat count.
  int          m_state = 0;
  int          m_mode = 0;
  logic [31:0] m_seed = 0;
  int          m_period = 0;
  logic [15:0] m_blen = 0;
  int          m_k = 0;
  int          m_en = 0;
  logic [31:0] m_data = 0;
  logic        m_valid = 0;
  int          m_ovr = 0;
  logic [31:0] m_chk = 0;
  logic        m_fire, m_acc;

  initial forever begin
    @(posedge clk or negedge n_rst);
    if (!n_rst) begin
      m_state = 0; m_data = 0; m_valid = 0; m_k = 0; m_ovr = 0; m_chk = 0; m_en = 0;
    end else begin
      m_fire = (m_state == 1) && enable && ((m_en % (m_period + 1)) == m_period);
      m_acc  = m_valid && strm.ready;
      case (m_state)
        0: if (start && !stop) begin
          m_state = 1; m_mode = int'(mode); m_seed = seed; m_period = int'(period);
          m_blen = burst_len; m_k = 0; m_en = 0; m_ovr = 0; m_chk = 0; m_valid = 0;
          m_data = word_at(int'(mode), seed, 0);
        end
        1: if (stop) begin
          m_state = 0; m_valid = 0;
        end else begin
          if (enable) m_en++;
          if (m_acc) begin
            m_chk = m_chk ^ m_data;
            m_k++;
            m_data = word_at(m_mode, m_seed, m_k);
            if (m_blen != 16'd0 && 16'(m_k) == m_blen) begin
              m_state = 2; m_valid = 0;
            end else begin
              m_valid = m_fire;
            end
          end else if (m_fire) begin
            if (!m_valid) m_valid = 1;
            else if (m_ovr < 65535) m_ovr++;
          end
        end
        default: m_state = 0;
      endcase
    end
  end

  // Compare process: outputs checked at negedge; accepts recorded just before the next posedge.
  initial forever begin
    @(negedge clk);
    if (n_rst) begin
      check("data", 64'(strm.data), 64'(m_data));
      check("valid", 64'(strm.valid), 64'(m_valid));
      check("busy", 64'(busy), 64'(m_state == 1));
      check("done", 64'(done), 64'(m_state == 2));
      check("beat_cnt", 64'(beat_cnt), 64'(16'(m_k)));
      check("overrun_cnt", 64'(overrun_cnt), 64'(m_ovr));
`ifdef STREAM_PATTERN_CHECKSUM_EN
      check("checksum", 64'(checksum), 64'(m_chk));
`endif
    end
    #4;
    if (n_rst && strm.valid && strm.ready) acc_q.push_back(strm.data);
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic launch(input logic [1:0] md, input logic [31:0] sd, input logic [7:0] per,
                        input logic [15:0] bl);
    acc_q.delete();
    mode = md; seed = sd; period = per; burst_len = bl; start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      cyc();
      if (done) seen = 1;
    end
    check({name, " done timeout"}, 64'(seen), 64'd1);
  endtask

  task automatic wait_valid(input string name, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      cyc();
      if (strm.valid) seen = 1;
    end
    check({name, " valid timeout"}, 64'(seen), 64'd1);
  endtask

  task automatic do_stop();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    strm.ready = 1'b0;
    repeat (3) cyc();
    check("rst data", 64'(strm.data), 64'd0);
    check("rst valid", 64'(strm.valid), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst beat", 64'(beat_cnt), 64'd0);
    n_rst = 1'b1;
    cyc();

    // Incrementing burst of 4 at one beat per 18 clocks.
    strm.ready = 1'b1;
    launch(2'd0, 32'h10, 8'd17, 16'd4);
    wait_done("incr", 200);
    check("incr count", 64'(acc_q.size()), 64'd4);
    check("incr w0", 64'(acc_q[0]), 64'h10);
    check("incr w3", 64'(acc_q[3]), 64'h13);
    check("incr beat", 64'(beat_cnt), 64'd4);
    check("incr ovr", 64'(overrun_cnt), 64'd0);
`ifdef STREAM_PATTERN_CHECKSUM_EN
    check("incr checksum", 64'(checksum), 64'h0);
`endif
    cyc();

    // Walking ones, continuous, back-to-back beats.
    launch(2'd2, 32'h0, 8'd0, 16'd0);
    repeat (40) cyc();
    do_stop();
    check("walk count", 64'(acc_q.size() >= 33), 64'd1);
    check("walk w0", 64'(acc_q[0]), 64'h1);
    check("walk w1", 64'(acc_q[1]), 64'h2);
    check("walk w31", 64'(acc_q[31]), 64'h8000_0000);
    check("walk w32", 64'(acc_q[32]), 64'h1);

    // LFSR from a zero seed for 100 beats.
    launch(2'd1, 32'h0, 8'd0, 16'd100);
    wait_done("lfsr", 300);
    check("lfsr count", 64'(acc_q.size()), 64'd100);
    check("lfsr w0", 64'(acc_q[0]), 64'h1);
    check("lfsr w1", 64'(acc_q[1]), 64'h3);
    check("lfsr w2", 64'(acc_q[2]), 64'h6);
    check("lfsr w3", 64'(acc_q[3]), 64'hD);
    cyc();

    // Backpressure: slots every 4 clocks while ready is low.
    strm.ready = 1'b0;
    launch(2'd0, 32'h55, 8'd3, 16'd0);
    wait_valid("ovr", 20);
    repeat (20) cyc();
    check("ovr count", 64'(overrun_cnt), 64'd5);
    check("ovr held data", 64'(strm.data), 64'h55);
    strm.ready = 1'b1;
    cyc();
    strm.ready = 1'b0;
    check("ovr first accepted", 64'(acc_q[0]), 64'h55);
    check("ovr next word", 64'(strm.data), 64'h56);
    do_stop();

    // Stop mid-burst.
    strm.ready = 1'b1;
    launch(2'd0, 32'hA0, 8'd2, 16'd8);
    for (int i = 0; i < 50 && beat_cnt != 16'd2; i++) cyc();
    check("stop beat2 reached", 64'(beat_cnt), 64'd2);
    do_stop();
    check("stop valid", 64'(strm.valid), 64'd0);
    check("stop busy", 64'(busy), 64'd0);
    check("stop done", 64'(done), 64'd0);
    repeat (3) cyc();
    check("stop done later", 64'(done), 64'd0);
    check("stop beat hold", 64'(beat_cnt), 64'd2);

    // start together with stop in idle is ignored.
    start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    check("start+stop idle", 64'(busy), 64'd0);

    // Timer freeze with a pending beat; acceptance still works while disabled.
    strm.ready = 1'b0;
    launch(2'd0, 32'h7, 8'd5, 16'd0);
    wait_valid("freeze", 20);
    enable = 1'b0;
    repeat (50) cyc();
    check("freeze ovr", 64'(overrun_cnt), 64'd0);
    check("freeze data", 64'(strm.data), 64'h7);
    strm.ready = 1'b1;
    cyc();
    strm.ready = 1'b0;
    check("freeze accept", 64'(acc_q[0]), 64'h7);
    check("freeze valid drop", 64'(strm.valid), 64'd0);
`ifdef STREAM_PATTERN_CHECKSUM_EN
    check("freeze checksum", 64'(checksum), 64'h7);
`endif
    enable = 1'b1;
    repeat (10) cyc();
    do_stop();

    // Asynchronous reset mid-run.
    strm.ready = 1'b1;
    launch(2'd3, 32'hDEAD_BEEF, 8'd0, 16'd0);
    repeat (10) cyc();
    #2 n_rst = 1'b0;
    #1;
    check("arst data", 64'(strm.data), 64'd0);
    check("arst valid", 64'(strm.valid), 64'd0);
    check("arst busy", 64'(busy), 64'd0);
    check("arst done", 64'(done), 64'd0);
    check("arst beat", 64'(beat_cnt), 64'd0);
    check("arst ovr", 64'(overrun_cnt), 64'd0);
    cyc();
    n_rst = 1'b1;
    cyc();

    // Randomised runs.
    for (int r = 0; r < 40; r++) begin
      strm.ready = 1'b1;
      launch(2'($urandom_range(0, 3)), $urandom, 8'($urandom_range(0, 4)),
             16'($urandom_range(0, 12)));
      for (int c = 0; c < 300 && (busy || done); c++) begin
        strm.ready = ($urandom_range(0, 3) != 0);
        enable = ($urandom_range(0, 7) != 0);
        stop = ($urandom_range(0, 149) == 0);
        start = busy && ($urandom_range(0, 19) == 0);
        cyc();
      end
      start = 1'b0;
      enable = 1'b1;
      do_stop();
    end

    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
